// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter family: shift-mode codes and the
// control-state encoding of the sequential right shifter.
package shifter_pkg;

  // Shift-mode codes; 2'b11 is not listed and behaves as logical.
  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  // Control states of the sequential shifter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_step.sv
// Combinational single-position right step. The vacated MSB is filled
// according to mode: zero (logical), old MSB (arithmetic) or old LSB (rotate).
module shift_right_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  logic fill;

  // Select the bit that enters at the MSB, then shift everything down by one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    fill = 1'b0;
    case (mode)
      MODE_ASR: fill = operand[WIDTH-1];
      MODE_ROR: fill = operand[0];
      default:  fill = 1'b0;
    endcase
    result = {fill, operand[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_right_shifter_8bit.sv
// Multi-cycle right shifter: one bit position per clock. Captures operand,
// distance and mode on an accepted start, steps until the count expires,
// then raises a one-cycle done with the result held on data_out.
module seq_right_shifter_8bit
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   amount,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sh_reg;
  logic [SHW-1:0]   cnt;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] stepped;
  logic             last_step;

  assign last_step = (cnt == SHW'(1));

  shift_right_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .operand (sh_reg),
    .mode    (mode_r),
    .result  (stepped)
  );

  // Next-state logic: IDLE -> SHIFT/DONE on start, SHIFT -> DONE on last step, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (amount == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_step) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state, so neither has an input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
    end
  end

  // Datapath: capture on accepted start, step and count down in SHIFT, load the result on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg   <= '0;
      cnt      <= '0;
      mode_r   <= MODE_LSR;
      data_out <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sh_reg <= data_in;
            cnt    <= amount;
            mode_r <= mode;
            if (amount == '0) begin
              data_out <= data_in;
            end
          end
        end
        ST_SHIFT: begin
          sh_reg <= stepped;
          cnt    <= cnt - SHW'(1);
          if (last_step) begin
            data_out <= stepped;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_right_shifter_8bit.sv
// Directed bench for seq_right_shifter_8bit: reset state, each shift mode,
// boundary distances, back-to-back starts, ignored start while busy, and
// reset abort mid-operation. Outputs are sampled on the falling edge.
module tb_seq_right_shifter_8bit;

  localparam logic [1:0] LSR = 2'b00;
  localparam logic [1:0] ASR = 2'b01;
  localparam logic [1:0] ROR = 2'b10;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data_in;
  logic [2:0] amount;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_right_shifter_8bit #(
    .WIDTH (8),
    .SHW   (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .amount   (amount),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one operation, scramble inputs after the capture edge, and wait
  // (bounded) for done. lat = cycle index after the start edge where done is
  // seen (0 = never). Also reports done/busy one cycle after the pulse.
  task automatic do_op(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                       output logic [7:0] res, output int lat,
                       output logic done_after, output logic busy_after);
    @(negedge clk);
    start = 1'b1; data_in = d; amount = a; mode = m;
    @(negedge clk);
    start = 1'b0; data_in = ~d; amount = ~a; mode = ~m;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    res = data_out;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data_in = 8'h00; amount = 3'd0; mode = LSR;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({busy, done, data_out} !== 10'h000) begin
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b data_out=%h, expected 0 0 00",
                 k, busy, done, data_out);
      end else pass_cnt++;
    end
  endtask

  task automatic test_lsr();
    logic [7:0] res; int lat; logic da, ba;
    do_op(8'h80, 3'd4, LSR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'h08) $display("FAIL lsr_80_4 data: got %h expected 08", res);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 5) $display("FAIL lsr_80_4 latency: got %0d expected 5", lat);
    else pass_cnt++;
    total_cnt++;
    if ({da, ba} !== 2'b00) $display("FAIL lsr_80_4 after_done: done=%b busy=%b expected 0 0", da, ba);
    else pass_cnt++;
  endtask

  task automatic test_asr_ror();
    logic [7:0] res; int lat; logic da, ba;
    do_op(8'h80, 3'd2, ASR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'hE0 || lat !== 3) $display("FAIL asr_80_2: got %h lat %0d expected E0 lat 3", res, lat);
    else pass_cnt++;
    do_op(8'h80, 3'd1, ROR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'h40 || lat !== 2) $display("FAIL ror_80_1: got %h lat %0d expected 40 lat 2", res, lat);
    else pass_cnt++;
  endtask

  task automatic test_boundaries();
    logic [7:0] res; int lat; logic da, ba;
    do_op(8'hFF, 3'd7, LSR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'h01 || lat !== 8) $display("FAIL lsr_ff_7: got %h lat %0d expected 01 lat 8", res, lat);
    else pass_cnt++;
    do_op(8'h01, 3'd1, ROR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'h80 || lat !== 2) $display("FAIL ror_01_1: got %h lat %0d expected 80 lat 2", res, lat);
    else pass_cnt++;
    do_op(8'hA5, 3'd0, ASR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'hA5 || lat !== 1) $display("FAIL amount_zero: got %h lat %0d expected A5 lat 1", res, lat);
    else pass_cnt++;
    total_cnt++;
    if ({da, ba} !== 2'b00) $display("FAIL amount_zero after_done: done=%b busy=%b expected 0 0", da, ba);
    else pass_cnt++;
    do_op(8'hB3, 3'd5, ROR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'h9D || lat !== 6) $display("FAIL ror_b3_5: got %h lat %0d expected 9D lat 6", res, lat);
    else pass_cnt++;
    do_op(8'hF0, 3'd3, 2'b11, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'h1E || lat !== 4) $display("FAIL mode11_f0_3: got %h lat %0d expected 1E lat 4", res, lat);
    else pass_cnt++;
    do_op(8'h7F, 3'd3, ASR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'h0F || lat !== 4) $display("FAIL asr_7f_3: got %h lat %0d expected 0F lat 4", res, lat);
    else pass_cnt++;
  endtask

  // start held high: a new operation on each return to IDLE.
  task automatic test_back_to_back();
    logic [5:0] seen;
    @(negedge clk);
    start = 1'b1; data_in = 8'h02; amount = 3'd1; mode = LSR;
    seen = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      seen[k-1] = done;
    end
    start = 1'b0;
    total_cnt++;
    if (seen !== 6'b010010) $display("FAIL back_to_back done pattern (cycle1=lsb): got %b expected 010010", seen);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'h01) $display("FAIL back_to_back data: got %h expected 01", data_out);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL back_to_back idle: busy=%b expected 0", busy);
    else pass_cnt++;
  endtask

  // A start pulse during SHIFT must not disturb the running operation.
  task automatic test_busy_ignore();
    int first; int ndone; logic busy_at_pulse;
    @(negedge clk);
    start = 1'b1; data_in = 8'hB4; amount = 3'd6; mode = ASR;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    busy_at_pulse = busy;
    start = 1'b1; data_in = 8'h55; amount = 3'd1; mode = ROR;
    @(negedge clk);
    start = 1'b0;
    first = 0; ndone = 0;
    for (int k = 3; k <= 20; k++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) first = k;
      end
      if (k == 7) begin
        total_cnt++;
        if (data_out !== 8'hFE) $display("FAIL busy_ignore data: got %h expected FE", data_out);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (busy_at_pulse !== 1'b1) $display("FAIL busy_ignore busy_during_shift: got %b expected 1", busy_at_pulse);
    else pass_cnt++;
    total_cnt++;
    if (first !== 7 || ndone !== 1)
      $display("FAIL busy_ignore done: first cycle %0d count %0d expected 7 and 1", first, ndone);
    else pass_cnt++;
  endtask

  // Reset mid-SHIFT aborts at once; a fresh operation afterwards works.
  task automatic test_reset_abort();
    logic [7:0] res; int lat; logic da, ba; int ndone;
    @(negedge clk);
    start = 1'b1; data_in = 8'hFF; amount = 3'd5; mode = LSR;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, data_out} !== 10'h000)
      $display("FAIL abort_immediate: busy=%b done=%b data_out=%h expected 0 0 00", busy, done, data_out);
    else pass_cnt++;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL abort_no_done: %0d cycles with done/busy set, expected 0", ndone);
    else pass_cnt++;
    do_op(8'h90, 3'd3, LSR, res, lat, da, ba);
    total_cnt++;
    if (res !== 8'h12 || lat !== 4) $display("FAIL after_abort_90_3: got %h lat %0d expected 12 lat 4", res, lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lsr();
    test_asr_ror();
    test_boundaries();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
